// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock at Clk/2, column/line counters, active-low syncs,
// blank, and a per-frame pulse and counter. Syncs and blank can be delayed to line up with registered RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       VGA_Clk,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..3");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  logic       pix_en;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic       h_wrap;
  logic       v_wrap;
  sync_t      raw_nxt;
  sync_t      pipe [SYNC_DELAY+1];

  // Raw sync/blank are decoded from the post-advance position so stage 0 matches DrawX/DrawY.
  always_comb begin
    h_wrap        = (hc == H_LAST);
    v_wrap        = (vc == V_LAST);
    hc_nxt        = h_wrap ? 10'd0 : hc + 10'd1;
    vc_nxt        = vc;
    if (h_wrap) begin
      vc_nxt      = v_wrap ? 10'd0 : vc + 10'd1;
    end
    raw_nxt.hs    = !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
    raw_nxt.vs    = !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
    raw_nxt.blank = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_en      <= 1'b0;
      VGA_Clk     <= 1'b0;
      hc          <= 10'd0;
      vc          <= 10'd0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
      for (int i = 0; i <= SYNC_DELAY; i++) begin
        pipe[i] <= SYNC_IDLE;
      end
    end else begin
      pix_en      <= ~pix_en;
      VGA_Clk     <= pix_en;
      frame_start <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        hc      <= hc_nxt;
        vc      <= vc_nxt;
        pipe[0] <= raw_nxt;
        for (int i = 1; i <= SYNC_DELAY; i++) begin
          pipe[i] <= pipe[i-1];
        end
        if (h_wrap && v_wrap) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

  assign hs    = pipe[SYNC_DELAY].hs;
  assign vs    = pipe[SYNC_DELAY].vs;
  assign blank = pipe[SYNC_DELAY].blank;
  assign DrawX = hc;
  assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-raster instances (sync delay 0/1/3) plus one default instance,
// compared every Clk against an arithmetic model of pixel index since reset release.
module tb_vga_timing_gen;

  localparam int NDUT = 4;
  localparam int P_HV [NDUT] = '{4, 4, 4, 640};
  localparam int P_HF [NDUT] = '{1, 1, 1, 16};
  localparam int P_HS [NDUT] = '{2, 2, 2, 96};
  localparam int P_HB [NDUT] = '{1, 1, 1, 48};
  localparam int P_VV [NDUT] = '{3, 3, 3, 480};
  localparam int P_VF [NDUT] = '{1, 1, 1, 10};
  localparam int P_VS [NDUT] = '{1, 1, 1, 2};
  localparam int P_VB [NDUT] = '{1, 1, 1, 33};
  localparam int P_D  [NDUT] = '{0, 1, 3, 1};

  logic       Clk;
  logic       Reset_n;
  logic       vga_clk_w [NDUT];
  logic       hs_w      [NDUT];
  logic       vs_w      [NDUT];
  logic       blank_w   [NDUT];
  logic       fs_w      [NDUT];
  logic [9:0] dx_w      [NDUT];
  logic [9:0] dy_w      [NDUT];
  logic [7:0] fc_w      [NDUT];

  int checks;
  int failures;
  int cur_dut;
  int k;  // edges since reset release minus one; -1 while in reset

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(0)
  ) u_d0 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_Clk(vga_clk_w[0]), .hs(hs_w[0]), .vs(vs_w[0]),
    .blank(blank_w[0]), .DrawX(dx_w[0]), .DrawY(dy_w[0]),
    .frame_start(fs_w[0]), .frame_count(fc_w[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(1)
  ) u_d1 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_Clk(vga_clk_w[1]), .hs(hs_w[1]), .vs(vs_w[1]),
    .blank(blank_w[1]), .DrawX(dx_w[1]), .DrawY(dy_w[1]),
    .frame_start(fs_w[1]), .frame_count(fc_w[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DELAY(3)
  ) u_d3 (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_Clk(vga_clk_w[2]), .hs(hs_w[2]), .vs(vs_w[2]),
    .blank(blank_w[2]), .DrawX(dx_w[2]), .DrawY(dy_w[2]),
    .frame_start(fs_w[2]), .frame_count(fc_w[2])
  );

  vga_timing_gen u_def (
    .Clk(Clk), .Reset_n(Reset_n), .VGA_Clk(vga_clk_w[3]), .hs(hs_w[3]), .vs(vs_w[3]),
    .blank(blank_w[3]), .DrawX(dx_w[3]), .DrawY(dy_w[3]),
    .frame_start(fs_w[3]), .frame_count(fc_w[3])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d k=%0d got=%0d exp=%0d", tag, cur_dut, k, got, exp);
    end
  endtask

  // Reference: after edge k the design has advanced n=(k+1)/2 pixels; everything follows from n.
  task automatic compare_all();
    int n, ht, vt, fr, m, hm, vm;
    logic e_vga, e_hs, e_vs, e_bl, e_fs;
    int e_x, e_y, e_fc;
    for (int i = 0; i < NDUT; i++) begin
      cur_dut = i;
      ht = P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
      vt = P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
      fr = ht * vt;
      e_vga = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0;
      e_x = 0; e_y = 0; e_fc = 0;
      if (k >= 0) begin
        n     = (k + 1) / 2;
        e_x   = n % ht;
        e_y   = (n / ht) % vt;
        e_vga = ((k % 2) == 1);
        e_fs  = ((k % 2) == 1) && (n > 0) && ((n % fr) == 0);
        e_fc  = (n / fr) % 256;
        m     = n - P_D[i];
        if (m >= 1) begin
          hm   = m % ht;
          vm   = (m / ht) % vt;
          e_hs = !((hm >= P_HV[i] + P_HF[i]) && (hm < P_HV[i] + P_HF[i] + P_HS[i]));
          e_vs = !((vm >= P_VV[i] + P_VF[i]) && (vm < P_VV[i] + P_VF[i] + P_VS[i]));
          e_bl = (hm < P_HV[i]) && (vm < P_VV[i]);
        end
      end
      check_eq("VGA_Clk", 32'(vga_clk_w[i]), 32'(e_vga));
      check_eq("DrawX", 32'(dx_w[i]), e_x);
      check_eq("DrawY", 32'(dy_w[i]), e_y);
      check_eq("hs", 32'(hs_w[i]), 32'(e_hs));
      check_eq("vs", 32'(vs_w[i]), 32'(e_vs));
      check_eq("blank", 32'(blank_w[i]), 32'(e_bl));
      check_eq("frame_start", 32'(fs_w[i]), 32'(e_fs));
      check_eq("frame_count", 32'(fc_w[i]), e_fc);
    end
  endtask

  task automatic step(input logic rst_n_val);
    Reset_n = rst_n_val;
    @(posedge Clk);
    if (!rst_n_val) k = -1;
    else            k = k + 1;
    @(negedge Clk);
    compare_all();
  endtask

  function automatic logic at_mid(input int kk);
    int n;
    n = (kk + 1) / 2;
    return (kk >= 0) && ((n % 8) == 5) && (((n / 8) % 6) == 3);
  endfunction

  initial begin
    int run_len;
    checks   = 0;
    failures = 0;
    cur_dut  = 0;
    k        = -1;
    Reset_n  = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b0);

    // Long run: well past 256 small frames so frame_count wraps, with a random tail.
    run_len = 2 * 48 * 258 + int'($urandom_range(0, 95));
    for (int i = 0; i < run_len; i++) step(1'b1);

    // Mid-frame reset on the small raster at column 5, line 3.
    for (int s = 0; s < 200 && !at_mid(k); s++) step(1'b1);
    cur_dut = 0;
    check_eq("mid_x", 32'(dx_w[0]), 32'd5);
    check_eq("mid_y", 32'(dy_w[0]), 32'd3);
    step(1'b0);

    for (int seg = 0; seg < 6; seg++) begin
      run_len = int'($urandom_range(1, 3));
      for (int i = 0; i < run_len; i++) step(1'b0);
      run_len = int'($urandom_range(10, 400));
      for (int i = 0; i < run_len; i++) step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
